// File: rtl/calc_pkg.sv
// Definitions shared by the keyboard-calculator pipeline stages.
// These cover the token layout, the operator codes and the error codes.
package calc_pkg;
    localparam int unsigned TOKEN_W = 33;
    localparam int unsigned OP_FLAG = 32;

    localparam logic [2:0] ADD        = 3'd0;
    localparam logic [2:0] SUB        = 3'd1;
    localparam logic [2:0] MUL        = 3'd2;
    localparam logic [2:0] DIV        = 3'd3;
    localparam logic [2:0] MO_NGOAC   = 3'd4;
    localparam logic [2:0] DONG_NGOAC = 3'd5;
    localparam logic [2:0] STOP       = 3'd6;

    localparam logic [1:0] ERR_NONE      = 2'd0;
    localparam logic [1:0] ERR_UNDERFLOW = 2'd1;
    localparam logic [1:0] ERR_OVERFLOW  = 2'd2;
    localparam logic [1:0] ERR_BADOP     = 2'd3;
endpackage

// File: rtl/udiv32.sv
// Restoring unsigned 32/32 divider. It produces one quotient bit per cycle.
// The done output asserts exactly 32 cycles after start.
module udiv32 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        start,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quotient,
    output logic        done
);
    logic [31:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
    logic [4:0]  step_q, step_d;
    logic        busy_q, busy_d, done_q, done_d;

    function automatic logic [63:0] div_step(input logic [31:0] rem, input logic [31:0] quo,
                                             input logic [31:0] dvs);
        logic [32:0] sh;
        logic [33:0] trial;
        sh    = {rem, quo[31]};
        trial = {1'b0, sh} - {2'b00, dvs};
        if (!trial[33]) return {trial[31:0], quo[30:0], 1'b1};
        return {sh[31:0], quo[30:0], 1'b0};
    endfunction

    // The first bit is resolved in the start cycle, which lets done land 32 cycles later.
    always_comb begin
        rem_d  = rem_q;
        quo_d  = quo_q;
        dvs_d  = dvs_q;
        step_d = step_q;
        busy_d = busy_q;
        done_d = 1'b0;
        if (start) begin
            {rem_d, quo_d} = div_step('0, dividend, divisor);
            dvs_d  = divisor;
            step_d = 5'd1;
            busy_d = 1'b1;
        end else if (busy_q) begin
            {rem_d, quo_d} = div_step(rem_q, quo_q, dvs_q);
            step_d = step_q + 5'd1;
            if (step_q == 5'd31) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q <= '0; quo_q <= '0; dvs_q <= '0;
            step_q <= '0; busy_q <= 1'b0; done_q <= 1'b0;
        end else if (clr) begin
            rem_q <= '0; quo_q <= '0; dvs_q <= '0;
            step_q <= '0; busy_q <= 1'b0; done_q <= 1'b0;
        end else begin
            rem_q <= rem_d; quo_q <= quo_d; dvs_q <= dvs_d;
            step_q <= step_d; busy_q <= busy_d; done_q <= done_d;
        end
    end

    assign quotient = quo_q;
    assign done     = done_q;
endmodule

// File: rtl/postfix_eval.sv
// Stack-based postfix evaluator. It pops tokens from the converter buffer and
// reports a signed 32-bit result, or a sticky error code.
module postfix_eval
    import calc_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               buf_not_empty,
    input  logic [TOKEN_W-1:0] in,
    output logic               rd,
    output logic [31:0]        result,
    output logic               done,
    output logic [1:0]         err
);
    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned CW = IW + 1;

    localparam logic [2:0] S_REQ  = 3'd0;
    localparam logic [2:0] S_DEC  = 3'd1;
    localparam logic [2:0] S_DIV  = 3'd2;
    localparam logic [2:0] S_DONE = 3'd3;
    localparam logic [2:0] S_ERR  = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    err_q, err_d;
    logic [31:0]   result_q, result_d;
    logic [31:0]   stk_q [DEPTH];

    logic          wr_en;
    logic [IW-1:0] wr_idx, top_idx, below_idx, push_idx;
    logic [31:0]   wr_data, opa, opb, alu, a_mag, b_mag, quo, div_res;
    logic          div_start, div_done, is_opnd, few, full;
    logic [2:0]    code;

    assign top_idx   = IW'(cnt_q - CW'(1));
    assign below_idx = IW'(cnt_q - CW'(2));
    assign push_idx  = IW'(cnt_q);
    assign opa       = stk_q[below_idx];
    assign opb       = stk_q[top_idx];
    assign is_opnd   = !in[OP_FLAG];
    assign code      = in[2:0];
    assign few       = cnt_q < CW'(2);
    assign full      = cnt_q == CW'(DEPTH);

    // The divider sees magnitudes only, and the sign is applied afterwards.
    // The stack is frozen during S_DIV, so opa and opb still hold the operands.
    assign a_mag   = opa[31] ? -opa : opa;
    assign b_mag   = opb[31] ? -opb : opb;
    assign div_res = (opa[31] ^ opb[31]) ? -quo : quo;

    always_comb begin
        alu = opa * opb;
        if (code == ADD) alu = opa + opb;
        else if (code == SUB) alu = opa - opb;
    end

    udiv32 u_div (
        .clk(clk), .rst_n(rst_n), .clr(clr), .start(div_start),
        .dividend(a_mag), .divisor(b_mag), .quotient(quo), .done(div_done)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        result_d  = result_q;
        rd        = 1'b0;
        div_start = 1'b0;
        wr_en     = 1'b0;
        wr_idx    = below_idx;
        wr_data   = alu;
        case (state_q)
            S_REQ: begin
                rd = buf_not_empty;
                if (buf_not_empty) state_d = S_DEC;
            end
            S_DEC: begin
                state_d = S_REQ;
                if (is_opnd) begin
                    if (full) begin
                        err_d = ERR_OVERFLOW; state_d = S_ERR;
                    end else begin
                        wr_en = 1'b1; wr_idx = push_idx; wr_data = in[31:0];
                        cnt_d = cnt_q + CW'(1);
                    end
                end else begin
                    case (code)
                        ADD, SUB, MUL: begin
                            if (few) begin
                                err_d = ERR_UNDERFLOW; state_d = S_ERR;
                            end else begin
                                wr_en = 1'b1; cnt_d = cnt_q - CW'(1);
                            end
                        end
                        DIV: begin
                            if (few) begin
                                err_d = ERR_UNDERFLOW; state_d = S_ERR;
                            end else if (opb == '0) begin
                                err_d = ERR_BADOP; state_d = S_ERR;
                            end else begin
                                div_start = 1'b1; state_d = S_DIV;
                            end
                        end
                        STOP: begin
                            if (cnt_q == CW'(1)) begin
                                result_d = opb; state_d = S_DONE;
                            end else begin
                                err_d = ERR_UNDERFLOW; state_d = S_ERR;
                            end
                        end
                        default: begin
                            err_d = ERR_BADOP; state_d = S_ERR;
                        end
                    endcase
                end
            end
            S_DIV: begin
                if (div_done) begin
                    wr_en = 1'b1; wr_data = div_res;
                    cnt_d = cnt_q - CW'(1); state_d = S_REQ;
                end
            end
            S_DONE: begin
                cnt_d = '0; state_d = S_REQ;
            end
            S_ERR: ;
            default: state_d = S_REQ;
        endcase
        if (clr) begin
            rd = 1'b0; div_start = 1'b0; wr_en = 1'b0;
            state_d = S_REQ; cnt_d = '0; err_d = ERR_NONE; result_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_REQ;
            cnt_q    <= '0;
            err_q    <= ERR_NONE;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            result_q <= result_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) stk_q[wr_idx] <= wr_data;
    end

    assign result = result_q;
    assign done   = (state_q == S_DONE) && !clr;
    assign err    = err_q;
endmodule
